fifo_drain_serializer: RTL and testbench
========================================

// Module: fifo_drain_serializer
// PURPOSE
//  Consumer stage directly downstream of the 8-deep, 8-bit synchronous FIFO.
//  Pops one byte at a time via read_from_stack and transmits it on a single wire as an async serial frame.
//  Frame: start bit, 8 data bits LSB first, optional parity bit, stop bit.
//  Drains the FIFO at line rate; the FIFO is the rate-matching buffer for the producer.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit; legal range 2..65535
//  DATA_W        8   byte width; must equal the FIFO data width
// PORTS
//  clk              in   1       system clock, rising edge; shared with the FIFO
//  rst              in   1       asynchronous reset, active-high
//  stack_empty      in   1       FIFO empty flag from the FIFO control logic
//  fifo_data        in   DATA_W  FIFO read data (Data_out of the FIFO)
//  read_from_stack  out  1       pop strobe to the FIFO; 1-cycle pulse per byte
//  tx               out  1       serial line; idles high
//  busy             out  1       high from pop until the end of the stop bit
//  frame_done       out  1       1-cycle pulse in the last cycle of the stop bit
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE; tx=1; read_from_stack=0; busy=0; frame_done=0; counters=0.
//  All outputs are registered (Moore). No combinational path from any input to any output.
//  FSM states and transitions:
//   IDLE  : stack_empty is sampled here only. If stack_empty==0, go to POP next cycle.
//   POP   : read_from_stack=1 for exactly this cycle; busy=1; next state LOAD.
//   LOAD  : FIFO read is registered, so fifo_data is valid in this cycle.
//           Capture fifo_data into the shift register; clear the baud counter; next state START.
//   START : tx=0 for CLKS_PER_BIT cycles, then go to DATA.
//   DATA  : tx=shreg[0] for CLKS_PER_BIT cycles per bit; shift right at each bit end.
//           After 8 bits, go to PAR (PARITY_EN defined) or STOP.
//   PAR   : tx=even parity (^byte) for CLKS_PER_BIT cycles, then go to STOP.
//   STOP  : tx=1 for CLKS_PER_BIT cycles; frame_done=1 in the final cycle; then go to IDLE.
//  Back-to-back bytes: at least one IDLE cycle separates frames (stop bit, then IDLE, then POP).
//  Pop-to-start latency: START begins 2 cycles after the POP cycle.
//  Frame period: (10 or 11)*CLKS_PER_BIT + 3 cycles.
//  Underflow cannot occur: a pop is issued only when stack_empty was 0 in IDLE.
//  stack_empty changing during a frame is ignored.
//  Simultaneous FIFO write during POP is legal; this block does not observe writes.
//  Reset mid-frame: tx returns high immediately and the in-flight byte is discarded (not re-popped).
//  A reset that coincides with POP drops that byte.
//  Baud counter width: $clog2(CLKS_PER_BIT). Bit counter: 3 bits, wraps 7->0 at DATA exit.
// CONFIGURATION
//  Macro SERIAL_PARITY_EN:
//   defined     -> PAR state present; 11-bit frame; parity is even over the 8 data bits.
//   not defined -> PAR state and parity logic absent; 10-bit frame; DATA goes straight to STOP.
// STRUCTURE
//  Package fifo_pkg holds:
//   - DATA_W=8 and ADDR_W=3 (shared with the FIFO and the dual-port RAM);
//   - the serializer state encoding (IDLE, POP, LOAD, START, DATA, PAR, STOP, 3 bits).
//  Sub-module baud_tick_gen(clk, rst, clr, tick): CLKS_PER_BIT divider.
//   - tick pulses in the last cycle of each bit period;
//   - clr restarts the count, asserted in LOAD.
//  Top level holds the FSM, shift register, bit counter and parity.
// TESTING  (CLKS_PER_BIT=4 unless stated)
//  1 Reset: assert rst mid-cycle -> tx=1, read_from_stack=0, busy=0 with no clock edge; stay idle while stack_empty=1.
//  2 Single byte 0xA5, no parity -> one pop pulse, then tx=0,1,0,1,0,0,1,0,1,1 (4 clk each); frame_done once.
//  3 SERIAL_PARITY_EN, bytes 0xA5 then 0x07 -> parity bits 0 then 1; 11-bit frames.
//  4 FIFO filled with 8 bytes 0x00..0x07 -> 8 pops and 8 frames in order; gap between stop end and next start = 3 cycles; no pop after empty.
//  5 rst asserted during DATA bit 3 of 0xFF -> tx=1 at once; after release the next byte in the FIFO is sent; 0xFF is not resent.
//  6 CLKS_PER_BIT=2 with FIFO writes concurrent to pops -> no lost or duplicated bytes; scoreboard vs write order.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO geometry and the serializer state encoding.
// Used by the FIFO, its dual-port RAM and fifo_drain_serializer.
package fifo_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        PAR   = 3'd5,
        STOP  = 3'd6
    } ser_state_t;

endpackage

// File: rtl/fifo_drain_serializer_baud_tick_gen.sv
// baud_tick_gen: divides clk by CLKS_PER_BIT; tick is high in the last cycle of each bit period.
// clr restarts the period so the next cycle is cycle 0 of a fresh bit.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: default assigned first so no branch leaves cnt_d unassigned and infers a latch.
        cnt_d = cnt + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // tick is kept as a flop that always equals (cnt == LAST), so it is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            cnt  <= cnt_d;
            tick <= (cnt_d == LAST);
        end
    end

endmodule

// File: rtl/fifo_drain_serializer.sv
// fifo_drain_serializer: pops bytes from the upstream FIFO and sends each as an async serial frame.
// Define SERIAL_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_drain_serializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = fifo_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stack_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              read_from_stack,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    import fifo_pkg::*;

    localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

    ser_state_t        state;
    ser_state_t        state_d;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_d;
    logic [2:0]        bit_cnt;
    logic              tick;
    logic              clr;
    logic              tx_d;
`ifdef SERIAL_PARITY_EN
    logic              parity;
`endif

    assign clr = (state == LOAD);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    // stack_empty is looked at only in IDLE; the FIFO may change freely mid-frame.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:  if (!stack_empty) state_d = POP;
            POP:   state_d = LOAD;
            LOAD:  state_d = START;
            START: if (tick) state_d = DATA;
            DATA: begin
                if (tick && bit_cnt == LAST_BIT) begin
`ifdef SERIAL_PARITY_EN
                    state_d = PAR;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef SERIAL_PARITY_EN
            PAR:   if (tick) state_d = STOP;
`endif
            STOP:  if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shreg_d = shreg;
        if (state == LOAD) begin
            shreg_d = fifo_data;
        end else if (state == DATA && tick) begin
            shreg_d = shreg >> 1;
        end
    end

    // The line level is derived from next-cycle state so tx comes straight out of a flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef SERIAL_PARITY_EN
            PAR:     tx_d = parity;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            shreg           <= '0;
            bit_cnt         <= '0;
            tx              <= 1'b1;
            busy            <= 1'b0;
            read_from_stack <= 1'b0;
        end else begin
            state           <= state_d;
            shreg           <= shreg_d;
            if (state == LOAD) begin
                bit_cnt <= '0;
            end else if (state == DATA && tick) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            tx              <= tx_d;
            busy            <= (state_d != IDLE);
            read_from_stack <= (state_d == POP);
        end
    end

`ifdef SERIAL_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (state == LOAD) begin
            parity <= ^fifo_data;
        end
    end
`endif

    // Both operands are flops, so the strobe has no path from any input.
    assign frame_done = (state == STOP) && tick;

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Bench for fifo_drain_serializer: behavioural FIFO models feed two instances (4 and 2 clocks per bit);
// frames are checked cycle by cycle against waveforms built from the byte values and write order.
module tb_fifo_drain_serializer;

    localparam int N1 = 4;
    localparam int N2 = 2;
`ifdef SERIAL_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int WAIT_LIMIT = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       se1 = 1'b1, se2 = 1'b1;
    logic [7:0] fd1 = '0, fd2 = '0;
    logic       rd1, rd2, tx1, tx2, busy1, busy2, fdn1, fdn2;
    logic       wr1 = 1'b0, wr2 = 1'b0;
    logic [7:0] wd1 = '0, wd2 = '0;
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] sb[$];

    int total = 0;
    int bad   = 0;
    int pops1 = 0;
    int pops2 = 0;

    fifo_drain_serializer #(.CLKS_PER_BIT(N1), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .stack_empty(se1), .fifo_data(fd1),
        .read_from_stack(rd1), .tx(tx1), .busy(busy1), .frame_done(fdn1)
    );

    fifo_drain_serializer #(.CLKS_PER_BIT(N2), .DATA_W(8)) dut2 (
        .clk(clk), .rst(rst), .stack_empty(se2), .fifo_data(fd2),
        .read_from_stack(rd2), .tx(tx2), .busy(busy2), .frame_done(fdn2)
    );

    // 8-deep FIFOs with registered read data and a registered empty flag; not reset by rst.
    always @(posedge clk) begin
        if (rd1 === 1'b1 && q1.size() > 0) fd1 <= q1.pop_front();
        if (wr1 && q1.size() < 8) q1.push_back(wd1);
        se1 <= (q1.size() == 0);
    end

    always @(posedge clk) begin
        if (rd2 === 1'b1 && q2.size() > 0) fd2 <= q2.pop_front();
        if (wr2 && q2.size() < 8) q2.push_back(wd2);
        se2 <= (q2.size() == 0);
    end

    always @(negedge clk) begin
        if (rd1 === 1'b1) pops1++;
        if (rd2 === 1'b1) pops2++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push1(input logic [7:0] d);
        wr1 = 1'b1;
        wd1 = d;
        @(negedge clk);
        wr1 = 1'b0;
    endtask

    task automatic push2(input logic [7:0] d);
        wr2 = 1'b1;
        wd2 = d;
        @(negedge clk);
        wr2 = 1'b0;
    endtask

    // Waits (bounded) for the falling start edge; returns on the negedge of the first START cycle.
    task automatic wait_start(input int sel, output int wc, output bit ok);
        wc = 0;
        while (((sel == 0) ? tx1 : tx2) !== 1'b0 && wc < WAIT_LIMIT) begin
            @(negedge clk);
            wc++;
        end
        ok = (((sel == 0) ? tx1 : tx2) === 1'b0);
        check("frame_start_seen", 32'(ok), 32'd1);
    endtask

    // Compares every cycle of one frame with the ideal waveform; seen[] holds mid-bit samples.
    task automatic frame_body(input int sel, input logic [7:0] data, output logic [10:0] seen);
        int n = (sel == 0) ? N1 : N2;
        int bad_w = 0, bad_fd = 0, bad_busy = 0;
        logic [10:0] want;
        logic t, f, b;
        want = '0;
        want[8:1] = data;
`ifdef SERIAL_PARITY_EN
        want[9] = ^data;
`endif
        want[NB-1] = 1'b1;
        seen = '0;
        for (int i = 0; i < NB; i++) begin
            for (int c = 0; c < n; c++) begin
                t = (sel == 0) ? tx1 : tx2;
                f = (sel == 0) ? fdn1 : fdn2;
                b = (sel == 0) ? busy1 : busy2;
                if (c == n / 2) seen[i] = t;
                if (t !== want[i]) bad_w++;
                if (f !== ((i == NB - 1) && (c == n - 1))) bad_fd++;
                if (b !== 1'b1) bad_busy++;
                @(negedge clk);
            end
        end
        check("frame_bits", 32'(seen), 32'(want));
        check("bit_width_errs", 32'(bad_w), 32'd0);
        check("frame_done_errs", 32'(bad_fd), 32'd0);
        check("busy_errs", 32'(bad_busy), 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       exp_par;
    } vec_t;

    vec_t       vecs[6];
    logic [10:0] seen;
    int         wc;
    bit         ok;
    int         p0;

    initial begin
        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h80, 1'b1};
        vecs[5] = '{8'h3C, 1'b0};

        // Reset asserted between clock edges must act at once.
        #2 rst = 1'b1;
        #1;
        check("rst_tx", 32'(tx1), 32'd1);
        check("rst_pop", 32'(rd1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_frame_done", 32'(fdn1), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_busy", 32'(busy1), 32'd0);
        check("idle_tx", 32'(tx1), 32'd1);
        check("idle_pops", 32'(pops1), 32'd0);

        // Single 0xA5 frame against the literal line sequence.
        p0 = pops1;
        push1(8'hA5);
        wait_start(0, wc, ok);
        if (ok) begin
            frame_body(0, 8'hA5, seen);
`ifdef SERIAL_PARITY_EN
            check("a5_line", 32'(seen), 32'(11'b10101001010));
`else
            check("a5_line", 32'(seen), 32'(10'b1101001010));
`endif
        end
        repeat (5) @(negedge clk);
        check("a5_pops", 32'(pops1 - p0), 32'd1);

        // Table-driven single frames.
        for (int v = 0; v < 6; v++) begin
            push1(vecs[v].data);
            wait_start(0, wc, ok);
            if (!ok) break;
            frame_body(0, vecs[v].data, seen);
`ifdef SERIAL_PARITY_EN
            check($sformatf("parity_%0d", v), 32'(seen[9]), 32'(vecs[v].exp_par));
`else
            check($sformatf("stop_%0d", v), 32'(seen[9]), 32'd1);
`endif
        end

        // Eight bytes back to back: order, 3-cycle gap, no pop once empty.
        repeat (5) @(negedge clk);
        p0 = pops1;
        fork
            begin
                for (int i = 0; i < 8; i++) push1(8'(i));
            end
            begin
                int gwc;
                bit gok;
                logic [10:0] gseen;
                for (int i = 0; i < 8; i++) begin
                    wait_start(0, gwc, gok);
                    if (!gok) break;
                    if (i > 0) check("gap_cycles", 32'(gwc), 32'd3);
                    frame_body(0, 8'(i), gseen);
                end
            end
        join
        repeat (40) @(negedge clk);
        check("burst_pops", 32'(pops1 - p0), 32'd8);
        check("burst_idle_busy", 32'(busy1), 32'd0);
        check("burst_idle_tx", 32'(tx1), 32'd1);

        // Reset during data bit 3 of 0xFF; 0x3C must follow and 0xFF must not be resent.
        p0 = pops1;
        push1(8'hFF);
        push1(8'h3C);
        wait_start(0, wc, ok);
        if (ok) begin
            repeat (N1 + 3 * N1 + 1) @(negedge clk);
            check("pre_rst_busy", 32'(busy1), 32'd1);
            #2 rst = 1'b1;
            #1;
            check("mid_rst_tx", 32'(tx1), 32'd1);
            check("mid_rst_busy", 32'(busy1), 32'd0);
            check("mid_rst_pop", 32'(rd1), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            wait_start(0, wc, ok);
            if (ok) frame_body(0, 8'h3C, seen);
            repeat (20) @(negedge clk);
            check("rst_pops", 32'(pops1 - p0), 32'd2);
            check("rst_fifo_drained", 32'(q1.size()), 32'd0);
        end

        // Two clocks per bit, random writes overlapping pops, scoreboard in write order.
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    int guard = 0;
                    repeat ($urandom_range(0, 30)) @(negedge clk);
                    while (q2.size() >= 8 && guard < WAIT_LIMIT) begin
                        @(negedge clk);
                        guard++;
                    end
                    begin
                        logic [7:0] d;
                        d = 8'($urandom);
                        sb.push_back(d);
                        push2(d);
                    end
                end
            end
            begin
                int rwc;
                bit rok;
                logic [10:0] rseen;
                logic [7:0] e;
                for (int k = 0; k < 40; k++) begin
                    wait_start(1, rwc, rok);
                    if (!rok) break;
                    check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
                    e = (sb.size() > 0) ? sb.pop_front() : 8'h00;
                    frame_body(1, e, rseen);
                end
            end
        join
        repeat (30) @(negedge clk);
        check("rand_sb_empty", 32'(sb.size()), 32'd0);
        check("rand_pops", 32'(pops2), 32'd40);
        check("rand_idle_busy", 32'(busy2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
